// File: rtl/popeye_dl_sequencer.sv
// popeye_dl_sequencer
// Steers the hps_io download stream into the Popeye core. Index-0 bytes go to one of
// four ROM regions. Index-254 bytes land in the DIP latches, and index-1 bytes land in
// the mod latch. The block also owns the core reset: the core is held in reset during a
// ROM download, and for a fixed settle time after a download or a user reset.
module popeye_dl_sequencer #(
    parameter logic [16:0] R1_BASE     = 17'h08000,
    parameter logic [16:0] R2_BASE     = 17'h0A000,
    parameter logic [16:0] R3_BASE     = 17'h12000,
    parameter logic [16:0] ROM_END     = 17'h12340,
    parameter int unsigned WR_CYCLES   = 2,
    parameter logic [15:0] RST_STRETCH = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        user_reset,
    output logic [3:0]  rom_we,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [63:0] sw,
    output logic [7:0]  mod,
    output logic        core_reset,
    output logic        dl_active,
    output logic        dl_short,
    output logic        dl_err
);

    typedef enum logic [2:0] {HOLD, RUN, LOAD, USER, SETTLE} state_e;

    localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] stretch_q, stretch_d;
    logic        dlShort_d;
    logic        coreReset_q, dlActive_q, dlShort_q, dlErr_q;
    logic [16:0] byteCnt_q;
    logic [3:0]  romWe_q;
    logic [16:0] romAddr_q;
    logic [7:0]  romData_q;
    logic        romWait_q;
    logic [3:0]  wrCnt_q;
    logic [63:0] sw_q;
    logic [7:0]  mod_q;

    logic        romDownload, loadEntry, romStrobe, inRange;
    logic        accept, outOfRange, busyHit;
    logic [16:0] lowAddr, regionBase;
    logic [1:0]  regionSel;

    assign romDownload = ioctl_download && (ioctl_index == 8'd0);
    assign lowAddr     = ioctl_addr[16:0];
    assign romStrobe   = ioctl_wr && (ioctl_index == 8'd0) && (state_q == LOAD);
    assign inRange     = (ioctl_addr[24:17] == 8'd0) && (lowAddr < ROM_END);
    assign accept      = romStrobe && !romWait_q && inRange;
    assign outOfRange  = romStrobe && !romWait_q && !inRange;
    assign busyHit     = romStrobe && romWait_q;
    assign loadEntry   = (state_d == LOAD) && (state_q != LOAD);

    // Next-state logic for the reset sequencer; a ROM download always wins over a user reset
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        dlShort_d = dlShort_q;
        case (state_q)
            HOLD: begin
                state_d   = SETTLE;
                stretch_d = RST_STRETCH;
            end
            RUN: begin
                if (romDownload) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    state_d = USER;
                end
            end
            LOAD: begin
                if (!romDownload) begin
                    state_d   = SETTLE;
                    stretch_d = RST_STRETCH;
                    dlShort_d = (byteCnt_q < ROM_END);
                end
            end
            USER: begin
                if (romDownload) begin
                    state_d = LOAD;
                end else if (!user_reset) begin
                    state_d   = SETTLE;
                    stretch_d = RST_STRETCH;
                end
            end
            SETTLE: begin
                if (romDownload) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    state_d = USER;
                end else if (stretch_q <= 16'd1) begin
                    state_d   = RUN;
                    stretch_d = 16'd0;
                end else begin
                    stretch_d = stretch_q - 16'd1;
                end
            end
            default: state_d = HOLD;
        endcase
        if (loadEntry) begin
            dlShort_d = 1'b0;
        end
    end

    // Sequencer state and its registered outputs, which are derived from the upcoming state
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            stretch_q   <= 16'd0;
            coreReset_q <= 1'b1;
            dlActive_q  <= 1'b0;
            dlShort_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stretch_q   <= stretch_d;
            coreReset_q <= (state_d != RUN);
            dlActive_q  <= (state_d == LOAD);
            dlShort_q   <= dlShort_d;
        end
    end

    // Region decode: the highest base not above the address selects the region
    always_comb begin
        regionSel  = 2'd0;
        regionBase = 17'd0;
        if (lowAddr >= R3_BASE) begin
            regionSel  = 2'd3;
            regionBase = R3_BASE;
        end else if (lowAddr >= R2_BASE) begin
            regionSel  = 2'd2;
            regionBase = R2_BASE;
        end else if (lowAddr >= R1_BASE) begin
            regionSel  = 2'd1;
            regionBase = R1_BASE;
        end
    end

    // ROM write engine: holds a one-hot strobe for WR_CYCLES clocks and tracks count/errors
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            romWe_q   <= 4'd0;
            romAddr_q <= 17'd0;
            romData_q <= 8'd0;
            romWait_q <= 1'b0;
            wrCnt_q   <= 4'd0;
            byteCnt_q <= 17'd0;
            dlErr_q   <= 1'b0;
        end else begin
            if (accept) begin
                romWe_q   <= 4'b0001 << regionSel;
                romAddr_q <= lowAddr - regionBase;
                romData_q <= ioctl_dout;
                romWait_q <= 1'b1;
                wrCnt_q   <= WR_LAST;
            end else if (romWe_q != 4'd0) begin
                if (wrCnt_q == 4'd0) begin
                    romWe_q   <= 4'd0;
                    romWait_q <= 1'b0;
                end else begin
                    wrCnt_q <= wrCnt_q - 4'd1;
                end
            end

            if (loadEntry) begin
                byteCnt_q <= 17'd0;
            end else if ((accept || outOfRange) && (byteCnt_q != 17'h1FFFF)) begin
                byteCnt_q <= byteCnt_q + 17'd1;
            end

            if (loadEntry) begin
                dlErr_q <= 1'b0;
            end else if (outOfRange || busyHit) begin
                dlErr_q <= 1'b1;
            end
        end
    end

    // DIP and mod latches accept bytes in any state and are cleared only by reset_n
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sw_q  <= 64'd0;
            mod_q <= 8'd0;
        end else begin
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
                sw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
            if (ioctl_wr && (ioctl_index == 8'd1)) begin
                mod_q <= ioctl_dout;
            end
        end
    end

    assign ioctl_wait = romWait_q;
    assign rom_we     = romWe_q;
    assign rom_addr   = romAddr_q;
    assign rom_data   = romData_q;
    assign sw         = sw_q;
    assign mod        = mod_q;
    assign core_reset = coreReset_q;
    assign dl_active  = dlActive_q;
    assign dl_short   = dlShort_q;
    assign dl_err     = dlErr_q;

endmodule

// File: tb/tb_popeye_dl_sequencer.sv
// tb_popeye_dl_sequencer
// Directed sequence with randomized data/addresses. A small behavioural model tracks
// the expected region/offset, DIP bytes, mod byte, byte count and sticky flags.
module tb_popeye_dl_sequencer;

   localparam logic [16:0] TB_R1   = 17'h00040;
   localparam logic [16:0] TB_R2   = 17'h00080;
   localparam logic [16:0] TB_R3   = 17'h000C0;
   localparam logic [16:0] TB_END  = 17'h00180;
   localparam int          TB_WR   = 2;
   localparam int          N       = 40;
   localparam int          BOUND   = 4 * N + 20;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        user_reset;
   logic [3:0]  rom_we;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic [63:0] sw;
   logic [7:0]  mod;
   logic        core_reset;
   logic        dl_active;
   logic        dl_short;
   logic        dl_err;

   int          tests = 0;
   int          failed = 0;
   logic [7:0]  swModel [8];
   logic [7:0]  modModel;
   logic        errModel;
   int          countModel;
   int          edges;
   int          total;

   popeye_dl_sequencer #(
      .R1_BASE    (TB_R1),
      .R2_BASE    (TB_R2),
      .R3_BASE    (TB_R3),
      .ROM_END    (TB_END),
      .WR_CYCLES  (TB_WR),
      .RST_STRETCH(16'(N))
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .ioctl_download(ioctl_download),
      .ioctl_index   (ioctl_index),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .ioctl_wait    (ioctl_wait),
      .user_reset    (user_reset),
      .rom_we        (rom_we),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .sw            (sw),
      .mod           (mod),
      .core_reset    (core_reset),
      .dl_active     (dl_active),
      .dl_short      (dl_short),
      .dl_err        (dl_err)
   );

   // Free-running 100 MHz bench clock
   always #5 clk_sys = ~clk_sys;

   // Compares one observed value against the model and reports a mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Base address of a region number in the bench parameterisation
   function automatic logic [16:0] baseOf(input int r);
      case (r)
         1:       return TB_R1;
         2:       return TB_R2;
         3:       return TB_R3;
         default: return 17'd0;
      endcase
   endfunction

   // Region an address falls into: the highest base not above it
   function automatic int regionOf(input logic [16:0] a);
      int r = 0;
      for (int k = 1; k < 4; k++) if (a >= baseOf(k)) r = k;
      return r;
   endfunction

   // Packs the DIP byte model into the 64-bit sw layout
   function automatic logic [63:0] packSw();
      logic [63:0] v = 64'd0;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = swModel[k];
      return v;
   endfunction

   // Counts clocks until core_reset drops, returning -1 if the bound expires
   task automatic waitCoreLow(input int bound, output int n);
      n = 0;
      while (core_reset !== 1'b0 && n < bound) begin
         @(negedge clk_sys);
         n++;
      end
      if (core_reset !== 1'b0) n = -1;
   endtask

   // Issues one index-0 byte and checks the write pulse, wait and error flag
   task automatic romWrite(input logic [24:0] addr, input logic [7:0] data);
      logic        ok;
      int          r;
      logic [16:0] off;
      logic [3:0]  oneHot;
      ok     = (addr[24:17] == 8'd0) && (addr[16:0] < TB_END);
      r      = regionOf(addr[16:0]);
      off    = addr[16:0] - baseOf(r);
      oneHot = 4'b0001 << r;
      ioctl_index = 8'd0;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      countModel++;
      if (!ok) errModel = 1'b1;
      if (ok) begin
         for (int c = 0; c < TB_WR; c++) begin
            checkOutput("rom_we", rom_we, oneHot);
            checkOutput("rom_addr", rom_addr, off);
            checkOutput("rom_data", rom_data, data);
            checkOutput("ioctl_wait", ioctl_wait, 1'b1);
            @(negedge clk_sys);
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            checkOutput("rom_we_oor", rom_we, 4'b0000);
            checkOutput("wait_oor", ioctl_wait, 1'b0);
            @(negedge clk_sys);
         end
      end
      checkOutput("rom_we_idle", rom_we, 4'b0000);
      checkOutput("wait_idle", ioctl_wait, 1'b0);
      checkOutput("dl_err", dl_err, errModel);
   endtask

   // Issues one DIP byte and checks the sw image
   task automatic dipWrite(input logic [24:0] addr, input logic [7:0] data);
      ioctl_index = 8'd254;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (addr[24:3] == 22'd0) swModel[addr[2:0]] = data;
      checkOutput("dip_sw", sw, packSw());
      checkOutput("dip_no_wait", ioctl_wait, 1'b0);
   endtask

   // Issues one mod byte and checks the mod latch
   task automatic modWrite(input logic [7:0] data);
      ioctl_index = 8'd1;
      ioctl_addr  = 25'd0;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      modModel = data;
      checkOutput("mod", mod, modModel);
   endtask

   // Raises download for index 0 and checks the LOAD entry state
   task automatic startRomDownload();
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      errModel   = 1'b0;
      countModel = 0;
      checkOutput("load_dl_active", dl_active, 1'b1);
      checkOutput("load_core_reset", core_reset, 1'b1);
      checkOutput("load_err_clear", dl_err, 1'b0);
      checkOutput("load_short_clear", dl_short, 1'b0);
   endtask

   // Drops download, checks the sticky flags and the settle window
   task automatic endRomDownload();
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      checkOutput("end_dl_short", dl_short, (countModel < int'(TB_END)));
      checkOutput("end_dl_err", dl_err, errModel);
      checkOutput("end_dl_active", dl_active, 1'b0);
      checkOutput("end_core_reset", core_reset, 1'b1);
      waitCoreLow(BOUND, edges);
      total = (edges < 0) ? -1 : edges + 1;
      checkOutput("settle_window", (total >= N && total <= N + 2), 1'b1);
   endtask

   // Main directed sequence
   initial begin
      logic [24:0] dipAddrs [12];
      dipAddrs = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd4, 25'd5, 25'd6, 25'd7,
                   25'd8, 25'h10, 25'h100, 25'h1000000};
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = 25'd0;
      ioctl_dout     = 8'd0;
      user_reset     = 1'b0;
      for (int k = 0; k < 8; k++) swModel[k] = 8'd0;
      modModel   = 8'd0;
      errModel   = 1'b0;
      countModel = 0;

      repeat (3) @(negedge clk_sys);
      checkOutput("rst_core_reset", core_reset, 1'b1);
      checkOutput("rst_rom_we", rom_we, 4'b0000);
      checkOutput("rst_wait", ioctl_wait, 1'b0);
      checkOutput("rst_sw", sw, 64'd0);
      checkOutput("rst_mod", mod, 8'd0);
      checkOutput("rst_dl_active", dl_active, 1'b0);
      checkOutput("rst_dl_err", dl_err, 1'b0);
      checkOutput("rst_dl_short", dl_short, 1'b0);
      reset_n = 1'b1;
      waitCoreLow(BOUND, edges);
      checkOutput("rst_stretch_window", (edges >= N + 1 && edges <= N + 2), 1'b1);

      dipWrite(25'd1, 8'hC2);
      checkOutput("dip_byte1", sw[15:8], 8'hC2);
      for (int k = 0; k < 12; k++) dipWrite(dipAddrs[$urandom_range(0, 11)], 8'($urandom));
      for (int k = 0; k < 4; k++) modWrite(8'($urandom));
      modWrite(8'($urandom) | 8'h01);

      startRomDownload();
      romWrite({8'h00, TB_R1 + 17'd1}, 8'h5A);
      for (int a = 0; a < int'(TB_END); a++) begin
         romWrite(25'(a), 8'($urandom));
         repeat ($urandom_range(0, 1)) @(negedge clk_sys);
      end
      endRomDownload();
      checkOutput("sw_survive_dl", sw, packSw());
      checkOutput("mod_survive_dl", mod, modModel);

      startRomDownload();
      for (int k = 0; k < 'h40; k++) romWrite(25'($urandom_range(0, int'(TB_END) - 1)), 8'($urandom));
      romWrite({8'h00, TB_END}, 8'hA5);
      romWrite(25'h0080010, 8'h3C);
      endRomDownload();

      startRomDownload();
      ioctl_index = 8'd0;
      ioctl_addr  = {8'h00, TB_R2 + 17'd5};
      ioctl_dout  = 8'h96;
      ioctl_wr    = 1'b1;
      countModel++;
      @(negedge clk_sys);
      checkOutput("busy_wait", ioctl_wait, 1'b1);
      checkOutput("busy_we_first", rom_we, 4'b0100);
      ioctl_addr = {8'h00, TB_R3 + 17'd3};
      ioctl_dout = 8'h69;
      errModel   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      checkOutput("busy_we_hold", rom_we, 4'b0100);
      checkOutput("busy_addr_hold", rom_addr, 17'd5);
      checkOutput("busy_data_hold", rom_data, 8'h96);
      edges = 2;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_sys);
         if (rom_we != 4'd0) edges++;
      end
      checkOutput("busy_single_pulse", edges, TB_WR);
      checkOutput("busy_dl_err", dl_err, 1'b1);
      for (int k = 0; k < 6; k++) romWrite(25'($urandom_range(0, int'(TB_END) - 1)), 8'($urandom));
      endRomDownload();

      user_reset = 1'b1;
      @(negedge clk_sys);
      checkOutput("user_core_reset", core_reset, 1'b1);
      repeat (3) @(negedge clk_sys);
      checkOutput("user_core_reset_hold", core_reset, 1'b1);
      user_reset = 1'b0;
      waitCoreLow(BOUND, edges);
      checkOutput("user_settle_window", (edges >= N && edges <= N + 2), 1'b1);
      checkOutput("sw_survive_user", sw, packSw());
      checkOutput("mod_survive_user", mod, modModel);

      startRomDownload();
      romWrite({8'h00, TB_END + 17'd2}, 8'h11);
      ioctl_index = 8'd0;
      ioctl_addr  = {8'h00, TB_R1};
      ioctl_dout  = 8'hE7;
      ioctl_wr    = 1'b1;
      @(posedge clk_sys);
      #2;
      checkOutput("pre_reset_we", rom_we, 4'b0010);
      reset_n = 1'b0;
      #1;
      checkOutput("async_rom_we", rom_we, 4'b0000);
      checkOutput("async_rom_addr", rom_addr, 17'd0);
      checkOutput("async_rom_data", rom_data, 8'd0);
      checkOutput("async_wait", ioctl_wait, 1'b0);
      checkOutput("async_sw", sw, 64'd0);
      checkOutput("async_mod", mod, 8'd0);
      checkOutput("async_core_reset", core_reset, 1'b1);
      checkOutput("async_dl_active", dl_active, 1'b0);
      checkOutput("async_dl_short", dl_short, 1'b0);
      checkOutput("async_dl_err", dl_err, 1'b0);
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
